fifo_param_sync: RTL and testbench
==================================

FIFO_PARAM_SYNC -- requirements
Module: fifo_param_sync

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 8: data width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W entries.
- AF_THRESH, DEPTH-2: Almost_full threshold.
- AE_THRESH, 2: Almost_empty threshold.
REQ-002 One clock; reset is asynchronous and active-low. Ports SHALL be:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous flush, active-high.
- WR_EN  in  1  write request.
- Din  in  WIDTH  write data.
- RD_EN  in  1  read request.
- Dout  out  WIDTH  registered read data.
- Valid  out  1  Dout holds newly read data this cycle.
- Empty  out  1  Count == 0.
- Full  out  1  Count == DEPTH.
- Almost_empty  out  1  Count <= AE_THRESH.
- Almost_full  out  1  Count >= AF_THRESH.
- Count  out  ADDR_W+1  occupancy, range 0..DEPTH.
- Overflow  out  1  sticky: a write was attempted while full.
- Underflow  out  1  sticky: a read was attempted while empty.

Function
REQ-003 Write accepted iff WR_EN=1 and Full=0: Din goes to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
REQ-004 Read accepted iff RD_EN=1 and Empty=0: Dout loads mem[rd_ptr] at that edge and rd_ptr increments modulo DEPTH.
REQ-005 Read latency SHALL be one cycle: Valid=1 for exactly the cycle after an accepted read, else 0; Dout holds its value when no read is accepted.
REQ-006 Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-007 Simultaneous WR_EN and RD_EN:
- Full: read accepted, write rejected.
- Empty: write accepted, read rejected.
- Otherwise: both accepted.
REQ-008 Empty, Full, Almost_empty and Almost_full SHALL be decoded from registered Count only, with no combinational path from any input.
REQ-009 Overflow SHALL set on any edge with WR_EN=1 and Full=1; Underflow on any edge with RD_EN=1 and Empty=1; both hold until CLR or RST.
REQ-010 CLR=1 SHALL take priority over WR_EN/RD_EN at that edge:
- Pointers, Count, Overflow, Underflow, Valid and Dout all go to 0.
- Memory contents are not cleared.
REQ-011 Data SHALL be returned in write order across any number of pointer wraps.
REQ-012 Memory SHALL be inferable as a simple dual-port RAM: one write port, one registered read port.

Reset
REQ-013 RST=0 SHALL immediately, without a clock, force:
- Pointers and Count to 0.
- Dout, Valid, Overflow, Underflow to 0.
- Empty=1, Almost_empty=1, Full=0, Almost_full=0.
REQ-014 Release of RST SHALL be synchronous to CLK; the first write is accepted at the first rising edge with RST=1.
REQ-015 RST asserted mid-operation SHALL discard all stored data; memory contents need not be cleared.

Verification (WIDTH=8, ADDR_W=4, AF_THRESH=14, AE_THRESH=2)
REQ-016 Reset: drive RST=0 between edges -> Count=0, Empty=1, Almost_empty=1, Full=0, Dout=0x00, Valid=0 before the next edge.
REQ-017 Fill and overflow:
- Write 0x01..0x10 -> Almost_empty=0 once Count=3, Almost_full=1 once Count=14, Full=1 at Count=16.
- 17th write -> Overflow=1, Count stays 16.
REQ-018 Drain and underflow:
- 16 reads -> Dout=0x01..0x10 in order, each with Valid=1 one cycle after its RD_EN.
- Then Empty=1; an extra read -> Underflow=1, Valid=0.
REQ-019 Simultaneous access:
- WR+RD at Count=5 -> Count stays 5.
- At Full -> Count=15, Overflow=1.
- At Empty -> Count=1, Underflow=1, Valid=0.
REQ-020 Wrap: 40 interleaved write/read pairs with incrementing data -> every read matches its write order, Count never exceeds 2.
REQ-021 Flush and mid-operation reset:
- CLR=1 with WR_EN=1 at Count=9 -> next cycle Count=0, Empty=1, write dropped, sticky flags cleared.
- RST=0 at Count=9 -> immediate Count=0, Empty=1.

Source files
------------

// File: rtl/fifo_param_sync.sv
// fifo_param_sync: synchronous FIFO with registered read port, threshold flags and sticky over/underflow
module fifo_param_sync #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = (2**ADDR_W) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              WR_EN,
  input  logic [WIDTH-1:0]  Din,
  input  logic              RD_EN,
  output logic [WIDTH-1:0]  Dout,
  output logic              Valid,
  output logic              Empty,
  output logic              Full,
  output logic              Almost_empty,
  output logic              Almost_full,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow,
  output logic              Underflow
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AE_THRESH);
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [WIDTH-1:0]  r_dout;
  logic              r_valid, r_ovf, r_udf;
  logic              w_wr, w_rd;
  assign Empty        = r_count == '0;
  assign Full         = r_count == LP_DEPTH;
  assign Almost_empty = r_count <= LP_AE;
  assign Almost_full  = r_count >= LP_AF;
  assign Count        = r_count;
  assign Dout         = r_dout;
  assign Valid        = r_valid;
  assign Overflow     = r_ovf;
  assign Underflow    = r_udf;
  assign w_wr = WR_EN && !Full;
  assign w_rd = RD_EN && !Empty;
  always_ff @(posedge CLK)
    if (w_wr && !CLR && RST) r_mem[r_wr_ptr] <= Din;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (CLR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_valid <= w_rd;
      r_count <= (w_wr && !w_rd) ? r_count + 1'b1 : (w_rd && !w_wr) ? r_count - 1'b1 : r_count;
      r_ovf   <= r_ovf || (WR_EN && Full);
      r_udf   <= r_udf || (RD_EN && Empty);
    end
endmodule

// File: tb/tb_fifo_param_sync.sv
// tb_fifo_param_sync: table vectors, directed corner sequences and random traffic against a queue model
module tb_fifo_param_sync;
  logic       CLK = 1'b0, RST = 1'b0, CLR = 1'b0, WR_EN = 1'b0, RD_EN = 1'b0;
  logic [7:0] Din = '0, Dout;
  logic       Valid, Empty, Full, Almost_empty, Almost_full, Overflow, Underflow;
  logic [4:0] Count;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_q [$];
  logic [7:0] m_dout = '0;
  logic       m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  typedef struct {
    logic clr, wr, rd;
    logic [7:0] din;
    int cnt;
    logic [7:0] dout;
    logic valid, ovf, udf;
  } vec_t;
  vec_t vt [9];
  fifo_param_sync #(.WIDTH(8), .ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WR_EN(WR_EN), .Din(Din), .RD_EN(RD_EN),
    .Dout(Dout), .Valid(Valid), .Empty(Empty), .Full(Full),
    .Almost_empty(Almost_empty), .Almost_full(Almost_full), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );
  always #5 CLK = ~CLK;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask
  task automatic model_step(input logic c, w, r, input logic [7:0] d);
    bit full, empty;
    full = m_q.size() == 16;
    empty = m_q.size() == 0;
    if (c) begin
      model_reset();
    end else begin
      if (w && full) m_ovf = 1'b1;
      if (r && empty) m_udf = 1'b1;
      m_valid = r && !empty;
      if (r && !empty) m_dout = m_q.pop_front();
      if (w && !full) m_q.push_back(d);
    end
  endtask
  task automatic check_model(input string tag);
    chk({tag, ".count"}, Count, m_q.size());
    chk({tag, ".empty"}, Empty, m_q.size() == 0);
    chk({tag, ".full"}, Full, m_q.size() == 16);
    chk({tag, ".aempty"}, Almost_empty, m_q.size() <= 2);
    chk({tag, ".afull"}, Almost_full, m_q.size() >= 14);
    chk({tag, ".dout"}, Dout, m_dout);
    chk({tag, ".valid"}, Valid, m_valid);
    chk({tag, ".ovf"}, Overflow, m_ovf);
    chk({tag, ".udf"}, Underflow, m_udf);
  endtask
  task automatic cyc(input logic c, w, r, input logic [7:0] d);
    CLR = c; WR_EN = w; RD_EN = r; Din = d;
    @(posedge CLK);
    model_step(c, w, r, d);
    #1;
    CLR = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0;
  endtask
  initial begin
    vt[0] = '{1'b0, 1'b1, 1'b0, 8'hA1, 1, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 8'hB2, 2, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'hA1, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 8'hC3, 1, 8'hB2, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 8'hB2, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'hC3, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'hC3, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b1, 8'hD4, 1, 8'hC3, 1'b0, 1'b0, 1'b1};
    vt[8] = '{1'b1, 1'b1, 1'b0, 8'hE5, 0, 8'h00, 1'b0, 1'b0, 1'b0};
    #12;
    check_model("reset");
    chk("reset.dout0", Dout, 8'h00);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(vt[i].clr, vt[i].wr, vt[i].rd, vt[i].din);
      chk($sformatf("vec%0d.count", i), Count, vt[i].cnt);
      chk($sformatf("vec%0d.dout", i), Dout, vt[i].dout);
      chk($sformatf("vec%0d.valid", i), Valid, vt[i].valid);
      chk($sformatf("vec%0d.ovf", i), Overflow, vt[i].ovf);
      chk($sformatf("vec%0d.udf", i), Underflow, vt[i].udf);
    end
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(i));
      check_model("fill");
      if (i == 2) chk("fill.ae_at2", Almost_empty, 1'b1);
      if (i == 3) chk("fill.ae_at3", Almost_empty, 1'b0);
      if (i == 13) chk("fill.af_at13", Almost_full, 1'b0);
      if (i == 14) chk("fill.af_at14", Almost_full, 1'b1);
      if (i == 15) chk("fill.full_at15", Full, 1'b0);
    end
    chk("fill.full_at16", Full, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'h11);
    chk("ovf.flag", Overflow, 1'b1);
    chk("ovf.count", Count, 5'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain.dout", Dout, i + 1);
      chk("drain.valid", Valid, 1'b1);
      check_model("drain");
    end
    chk("drain.empty", Empty, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("udf.flag", Underflow, 1'b1);
    chk("udf.valid", Valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
    cyc(1'b0, 1'b1, 1'b1, 8'h55);
    chk("sim5.count", Count, 5'd5);
    check_model("sim5");
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    cyc(1'b0, 1'b1, 1'b1, 8'h77);
    chk("simfull.count", Count, 5'd15);
    chk("simfull.ovf", Overflow, 1'b1);
    check_model("simfull");
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 8'h88);
    chk("simempty.count", Count, 5'd1);
    chk("simempty.udf", Underflow, 1'b1);
    chk("simempty.valid", Valid, 1'b0);
    check_model("simempty");
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(i));
      chk("wrap.count_max", Count <= 5'd2, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("wrap.dout", Dout, 8'(i));
      check_model("wrap");
    end
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp, 8'($urandom));
      check_model("rand");
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("pre_clr.count", Count, 5'd9);
    chk("pre_clr.sticky", {Overflow, Underflow}, 2'b11);
    cyc(1'b1, 1'b1, 1'b0, 8'h99);
    chk("clr.count", Count, 5'd0);
    chk("clr.empty", Empty, 1'b1);
    chk("clr.ovf", Overflow, 1'b0);
    chk("clr.udf", Underflow, 1'b0);
    check_model("clr");
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    chk("arst.count", Count, 5'd0);
    chk("arst.empty", Empty, 1'b1);
    check_model("arst");
    @(negedge CLK);
    RST = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 8'h3C);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("post_rst.dout", Dout, 8'h3C);
    check_model("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
